// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, EXE->MEM field offsets
// and a helper that unpacks the EXE->MEM payload into named fields.
package mem_stage_pkg;

    localparam int ES_BUS_W  = 172;
    localparam int MS_BUS_W  = 118;
    localparam int DISC_W    = 2;

    // EXE->MEM field offsets
    localparam int ES_RESULT_LSB = 0;
    localparam int ES_PC_LSB     = 32;
    localparam int ES_DEST_LSB   = 64;
    localparam int ES_GRWE_LSB   = 69;
    localparam int ES_LOAD_OP    = 73;
    localparam int ES_MEM_WE     = 74;
    localparam int ES_BYTE       = 75;
    localparam int ES_HALF       = 76;
    localparam int ES_WORD       = 77;
    localparam int ES_WL         = 78;
    localparam int ES_WR         = 79;
    localparam int ES_LOAD_U     = 80;
    localparam int ES_EXT        = 81;
    // Exception info forwarded to WB starts at the ext flag itself
    localparam int ES_INFO_LSB   = 81;
    localparam int MS_INFO_W     = 45;

    typedef struct packed {
        logic        ext;
        logic        load_u;
        logic        ld_wr;
        logic        ld_wl;
        logic        ld_word;
        logic        ld_half;
        logic        ld_byte;
        logic        mem_we;
        logic        load_op;
        logic [3:0]  gr_we;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [31:0] result;
    } es_fields_t;

    function automatic es_fields_t unpack_es(input logic [ES_BUS_W-1:0] bus);
        es_fields_t f;
        f.result  = bus[ES_RESULT_LSB +: 32];
        f.pc      = bus[ES_PC_LSB +: 32];
        f.dest    = bus[ES_DEST_LSB +: 5];
        f.gr_we   = bus[ES_GRWE_LSB +: 4];
        f.load_op = bus[ES_LOAD_OP];
        f.mem_we  = bus[ES_MEM_WE];
        f.ld_byte = bus[ES_BYTE];
        f.ld_half = bus[ES_HALF];
        f.ld_word = bus[ES_WORD];
        f.ld_wl   = bus[ES_WL];
        f.ld_wr   = bus[ES_WR];
        f.load_u  = bus[ES_LOAD_U];
        f.ext     = bus[ES_EXT];
        return f;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks/extends bytes and halfwords, shifts for lwl/lwr.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic        i_byte,
    input  logic        i_half,
    input  logic        i_wl,
    input  logic        i_wr,
    input  logic        i_load_u,
    output logic [31:0] o_aligned
);

    logic [31:0] w_shr;
    logic [15:0] w_half;

    // Select and extend the addressed part of the response word
    always_comb begin
        w_shr  = i_rdata >> {i_off, 3'b000};
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        if (i_byte) begin
            o_aligned = {{24{w_shr[7] & ~i_load_u}}, w_shr[7:0]};
        end else if (i_half) begin
            o_aligned = {{16{w_half[15] & ~i_load_u}}, w_half};
        end else if (i_wl) begin
            // 3 - off == ~off for a 2-bit offset
            o_aligned = i_rdata << {~i_off, 3'b000};
        end else if (i_wr) begin
            o_aligned = w_shr;
        end else begin
            o_aligned = i_rdata;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for data responses, aligns load data, forwards
// results and drops responses owed to flushed requests.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ES_TO_MS_BUS_WD = ES_BUS_W,
    parameter int MS_TO_WS_BUS_WD = MS_BUS_W,
    parameter int DISCARD_W       = DISC_W
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       ws_flush,
    input  logic                       es_req_pending,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [41:0]                ms_forward_bus,
    output logic [33:0]                ms_to_es_bus
);

    logic                       r_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] r_bus;
    logic                       r_data_ok_seen;
    logic [31:0]                r_rdata_buf;
    logic [DISCARD_W-1:0]       r_discard_cnt;

    es_fields_t      w_es;
    logic            w_owned;
    logic            w_need_data;
    logic            w_ready_go;
    logic            w_leave;
    logic            w_is_load;
    logic [31:0]     w_load_data;
    logic [31:0]     w_aligned;
    logic [31:0]     w_final;
    logic [DISCARD_W:0]   w_cnt_sum;
    logic [DISCARD_W-1:0] w_cnt_next;
    logic            w_unused_ok;

    assign w_es        = unpack_es(r_bus);
    assign w_owned     = data_sram_data_ok & (r_discard_cnt == {DISCARD_W{1'b0}});
    assign w_need_data = r_ms_valid & (w_es.load_op | w_es.mem_we) & ~w_es.ext;
    assign w_ready_go  = ~w_need_data | r_data_ok_seen | w_owned;
    assign w_leave     = r_ms_valid & w_ready_go & ws_allowin;
    assign w_is_load   = r_ms_valid & w_es.load_op & ~w_es.ext;
    assign w_load_data = r_data_ok_seen ? r_rdata_buf : data_sram_rdata;
    assign w_final     = (w_es.load_op & ~w_es.ext) ? w_aligned : w_es.result;
    assign w_unused_ok = ^{r_bus[ES_TO_MS_BUS_WD-1:ES_INFO_LSB+MS_INFO_W], w_es.ld_word};

    mem_stage_load_align u_load_align (
        .i_rdata   (w_load_data),
        .i_off     (w_es.result[1:0]),
        .i_byte    (w_es.ld_byte),
        .i_half    (w_es.ld_half),
        .i_wl      (w_es.ld_wl),
        .i_wr      (w_es.ld_wr),
        .i_load_u  (w_es.load_u),
        .o_aligned (w_aligned)
    );

    // Orphan-response counter: flush adds the lost responses, a dropped response removes one
    always_comb begin
        w_cnt_sum = {1'b0, r_discard_cnt};
        if (ws_flush) begin
            w_cnt_sum = w_cnt_sum
                      + {{DISCARD_W{1'b0}}, (w_need_data & ~r_data_ok_seen & ~w_owned)}
                      + {{DISCARD_W{1'b0}}, es_req_pending};
        end else begin
            w_cnt_sum = w_cnt_sum;
        end
        if (data_sram_data_ok & ~w_owned) begin
            w_cnt_sum = w_cnt_sum - {{DISCARD_W{1'b0}}, 1'b1};
        end else begin
            w_cnt_sum = w_cnt_sum;
        end
        if (w_cnt_sum > {1'b0, {DISCARD_W{1'b1}}}) begin
            w_cnt_next = {DISCARD_W{1'b1}};
        end else begin
            w_cnt_next = w_cnt_sum[DISCARD_W-1:0];
        end
    end

    // Stage valid, payload, response buffer and discard counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid     <= 1'b0;
            r_bus          <= {ES_TO_MS_BUS_WD{1'b0}};
            r_data_ok_seen <= 1'b0;
            r_rdata_buf    <= 32'h0000_0000;
            r_discard_cnt  <= {DISCARD_W{1'b0}};
        end else begin
            if (ws_flush) begin
                r_ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                r_ms_valid <= es_to_ms_valid;
            end else begin
                r_ms_valid <= r_ms_valid;
            end
            if (es_to_ms_valid & ms_allowin) begin
                r_bus <= es_to_ms_bus;
            end else begin
                r_bus <= r_bus;
            end
            // Hold an early response until WB can take the instruction
            if (ws_flush | w_leave) begin
                r_data_ok_seen <= 1'b0;
                r_rdata_buf    <= 32'h0000_0000;
            end else if (w_owned & r_ms_valid & ~(w_ready_go & ws_allowin)) begin
                r_data_ok_seen <= 1'b1;
                r_rdata_buf    <= data_sram_rdata;
            end else begin
                r_data_ok_seen <= r_data_ok_seen;
                r_rdata_buf    <= r_rdata_buf;
            end
            r_discard_cnt <= w_cnt_next;
        end
    end

    assign ms_allowin     = ~r_ms_valid | (w_ready_go & ws_allowin);
    assign ms_to_ws_valid = r_ms_valid & w_ready_go;
    assign ms_to_ws_bus   = {w_es.gr_we, w_es.dest, w_final, w_es.pc,
                             r_bus[ES_INFO_LSB +: MS_INFO_W]};
    assign ms_forward_bus = {w_is_load & ~w_ready_go, {4{r_ms_valid}} & w_es.gr_we,
                             w_es.dest, w_final};
    assign ms_to_es_bus   = {ws_flush, w_is_load, w_es.result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: load alignment, response
// buffering, flush discard accounting, exception pass-through and reset.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [171:0] es_to_ms_bus;
    logic         ws_flush;
    logic         es_req_pending;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         ms_to_ws_valid;
    logic [117:0] ms_to_ws_bus;
    logic [41:0]  ms_forward_bus;
    logic [33:0]  ms_to_es_bus;

    int n_total = 0;
    int n_bad   = 0;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ws_flush          (ws_flush),
        .es_req_pending    (es_req_pending),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_forward_bus    (ms_forward_bus),
        .ms_to_es_bus      (ms_to_es_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [171:0] mk(input logic [31:0] res, input logic [3:0] we,
                                        input logic ld, input logic st, input logic b,
                                        input logic h, input logic wl, input logic wr,
                                        input logic u, input logic x);
        logic [171:0] v;
        v = 172'd0;
        v[ES_RESULT_LSB +: 32] = res;
        v[ES_PC_LSB +: 32]     = 32'hBFC0_0100;
        v[ES_DEST_LSB +: 5]    = 5'd9;
        v[ES_GRWE_LSB +: 4]    = we;
        v[ES_LOAD_OP]          = ld;
        v[ES_MEM_WE]           = st;
        v[ES_BYTE]             = b;
        v[ES_HALF]             = h;
        v[ES_WORD]             = ld & ~b & ~h & ~wl & ~wr;
        v[ES_WL]               = wl;
        v[ES_WR]               = wr;
        v[ES_LOAD_U]           = u;
        v[ES_EXT]              = x;
        return v;
    endfunction

    task automatic issue(input logic [171:0] b);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
        tick();
        es_to_ms_valid = 1'b0;
    endtask

    // Load whose response arrives in its first MEM cycle
    task automatic load_chk(input string tag, input logic [171:0] b, input logic [31:0] rd,
                            input logic [31:0] exp, input logic [3:0] we);
        issue(b);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        #1;
        chk({tag, "_vld"}, {31'd0, ms_to_ws_valid}, 32'd1);
        chk({tag, "_res"}, ms_to_ws_bus[108:77], exp);
        chk({tag, "_we"},  {28'd0, ms_to_ws_bus[117:114]}, {28'd0, we});
        tick();
        data_sram_data_ok = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = 172'd0;
        ws_flush = 1'b0; es_req_pending = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_vld",   {31'd0, ms_to_ws_valid}, 32'd0);
        chk("rst_allow", {31'd0, ms_allowin}, 32'd1);
        chk("rst_block", {31'd0, ms_forward_bus[41]}, 32'd0);
        chk("rst_fwdwe", {28'd0, ms_forward_bus[40:37]}, 32'd0);
        chk("rst_isld",  {31'd0, ms_to_es_bus[32]}, 32'd0);
        chk("rst_disc",  32'(dut.r_discard_cnt), 32'd0);

        // lw: one waiting cycle, then response in cycle 2
        issue(mk(32'h0000_1000, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        #1;
        chk("lw_wait_vld",   {31'd0, ms_to_ws_valid}, 32'd0);
        chk("lw_wait_block", {31'd0, ms_forward_bus[41]}, 32'd1);
        chk("lw_wait_allow", {31'd0, ms_allowin}, 32'd0);
        chk("lw_isld",       {31'd0, ms_to_es_bus[32]}, 32'd1);
        chk("lw_addr",       ms_to_es_bus[31:0], 32'h0000_1000);
        chk("lw_fwdwe",      {28'd0, ms_forward_bus[40:37]}, 32'hF);
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_5678;
        #1;
        chk("lw_vld",   {31'd0, ms_to_ws_valid}, 32'd1);
        chk("lw_res",   ms_to_ws_bus[108:77], 32'h1234_5678);
        chk("lw_fwd",   ms_forward_bus[31:0], 32'h1234_5678);
        chk("lw_block", {31'd0, ms_forward_bus[41]}, 32'd0);
        chk("lw_pc",    ms_to_ws_bus[76:45], 32'hBFC0_0100);
        tick();
        data_sram_data_ok = 1'b0;

        load_chk("lb",  mk(32'h0000_2003, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                 32'h8012_3456, 32'hFFFF_FF80, 4'hF);
        load_chk("lbu", mk(32'h0000_2003, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0),
                 32'h8012_3456, 32'h0000_0080, 4'hF);
        load_chk("lh",  mk(32'h0000_2002, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0),
                 32'h8001_5555, 32'hFFFF_8001, 4'hF);
        load_chk("lhu", mk(32'h0000_2000, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0),
                 32'h8001_9ABC, 32'h0000_9ABC, 4'hF);
        load_chk("lwl", mk(32'h0000_2001, 4'b1100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0),
                 32'hAABB_CCDD, 32'hCCDD_0000, 4'b1100);
        load_chk("lwr", mk(32'h0000_2002, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
                 32'hAABB_CCDD, 32'h0000_AABB, 4'b0011);

        // Response while WB is stalled is buffered
        issue(mk(32'h0000_3000, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
        #1;
        chk("buf_vld0",  {31'd0, ms_to_ws_valid}, 32'd1);
        chk("buf_allow", {31'd0, ms_allowin}, 32'd0);
        tick();
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0BAD_F00D;
        #1;
        chk("buf_hold", ms_to_ws_bus[108:77], 32'hDEAD_BEEF);
        tick();
        ws_allowin = 1'b1;
        #1;
        chk("buf_vld1", {31'd0, ms_to_ws_valid}, 32'd1);
        chk("buf_res",  ms_to_ws_bus[108:77], 32'hDEAD_BEEF);
        tick();
        chk("buf_gone", {31'd0, ms_to_ws_valid}, 32'd0);

        // Flush with a waiting load and a pending EXE request -> two orphans
        issue(mk(32'h0000_4000, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        ws_flush = 1'b1; es_req_pending = 1'b1;
        #1;
        chk("fl_msflush", {31'd0, ms_to_es_bus[33]}, 32'd1);
        tick();
        ws_flush = 1'b0; es_req_pending = 1'b0;
        chk("fl_disc2", 32'(dut.r_discard_cnt), 32'd2);
        chk("fl_vld",   {31'd0, ms_to_ws_valid}, 32'd0);
        issue(mk(32'h0000_5000, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
        #1;
        chk("fl_drop1", {31'd0, ms_to_ws_valid}, 32'd0);
        tick();
        data_sram_rdata = 32'h2222_2222;
        #1;
        chk("fl_drop2", {31'd0, ms_to_ws_valid}, 32'd0);
        chk("fl_disc1", 32'(dut.r_discard_cnt), 32'd1);
        tick();
        data_sram_rdata = 32'h3333_3333;
        #1;
        chk("fl_disc0", 32'(dut.r_discard_cnt), 32'd0);
        chk("fl_vld3",  {31'd0, ms_to_ws_valid}, 32'd1);
        chk("fl_res3",  ms_to_ws_bus[108:77], 32'h3333_3333);
        tick();
        data_sram_data_ok = 1'b0;

        // Store with exception: no wait, badvaddr passes through
        issue(mk(32'h0000_0003, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        #1;
        chk("ext_vld",   {31'd0, ms_to_ws_valid}, 32'd1);
        chk("ext_res",   ms_to_ws_bus[108:77], 32'h0000_0003);
        chk("ext_block", {31'd0, ms_forward_bus[41]}, 32'd0);
        chk("ext_info",  {31'd0, ms_to_ws_bus[0]}, 32'd1);
        tick();

        // Reset while waiting with orphans counted
        issue(mk(32'h0000_6000, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        ws_flush = 1'b1; es_req_pending = 1'b1;
        tick();
        ws_flush = 1'b0; es_req_pending = 1'b0;
        issue(mk(32'h0000_7000, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("rw_disc_pre", 32'(dut.r_discard_cnt), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rw_vld",   {31'd0, ms_to_ws_valid}, 32'd0);
        chk("rw_allow", {31'd0, ms_allowin}, 32'd1);
        chk("rw_disc",  32'(dut.r_discard_cnt), 32'd0);
        chk("rw_fwdwe", {28'd0, ms_forward_bus[40:37]}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
